// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: FSM states, instruction classes,
// opcode map, ALU select encodings and instruction field positions.
package ctrl_pkg;

    localparam int unsigned INSTR_W = 19;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB = 18;
    localparam int unsigned OPC_LSB = 14;
    localparam int unsigned RD_MSB  = 13;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS1_MSB = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_MSB = 5;
    localparam int unsigned RS2_LSB = 2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_JMP,
        CLS_BEQ,
        CLS_BNE,
        CLS_LD,
        CLS_ST,
        CLS_HALT,
        CLS_NONE
    } iclass_t;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_SLL  = 5'h04;
    localparam logic [4:0] OP_SRL  = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_INC  = 5'h08;
    localparam logic [4:0] OP_DEC  = 5'h09;
    localparam logic [4:0] OP_NOT  = 5'h0A;
    localparam logic [4:0] OP_JMP  = 5'h0C;
    localparam logic [4:0] OP_BEQ  = 5'h0D;
    localparam logic [4:0] OP_BNE  = 5'h0E;
    localparam logic [4:0] OP_LD   = 5'h0F;
    localparam logic [4:0] OP_ST   = 5'h10;
    localparam logic [4:0] OP_HALT = 5'h1F;

    // ALU function selects (alu_l = 0)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    // Unary ALU selects (alu_l = 1)
    localparam logic [2:0] UALU_INC = 3'b000;
    localparam logic [2:0] UALU_DEC = 3'b001;
    localparam logic [2:0] UALU_NOT = 3'b010;

    // True for instructions that change control flow and retire in EXEC
    function automatic logic is_flow(input iclass_t c);
        return (c == CLS_JMP) || (c == CLS_BEQ) || (c == CLS_BNE);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode to its ALU select, unary
// modifier, instruction class and an illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [2:0] alu_ctrl,
    output logic       alu_l,
    output iclass_t    iclass,
    output logic       illegal
);

    // Opcode map lookup; anything not listed is illegal
    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_l    = 1'b0;
        iclass   = CLS_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_XOR: begin
                iclass   = CLS_ALU;
                alu_ctrl = opcode[2:0];
            end
            OP_INC: begin
                iclass   = CLS_ALU;
                alu_l    = 1'b1;
                alu_ctrl = UALU_INC;
            end
            OP_DEC: begin
                iclass   = CLS_ALU;
                alu_l    = 1'b1;
                alu_ctrl = UALU_DEC;
            end
            OP_NOT: begin
                iclass   = CLS_ALU;
                alu_l    = 1'b1;
                alu_ctrl = UALU_NOT;
            end
            OP_JMP: begin
                iclass   = CLS_JMP;
                alu_ctrl = ALU_SUB;
            end
            OP_BEQ: begin
                iclass   = CLS_BEQ;
                alu_ctrl = ALU_SUB;
            end
            OP_BNE: begin
                iclass   = CLS_BNE;
                alu_ctrl = ALU_SUB;
            end
            OP_LD:   iclass = CLS_LD;
            OP_ST:   iclass = CLS_ST;
            OP_HALT: iclass = CLS_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control FSM: fetch over req/valid, decode, execute, memory
// access and write-back, with branch resolution from the ALU zero flag.
// Optional build macro CTRL_PERF_CNT_EN adds a saturating 32-bit
// retired-instruction counter on output 'retired'.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [2:0]          alu_ctrl,
    output logic                alu_l,
    input  logic                alu_zero,
    output logic [3:0]          rf_raddr1,
    output logic [3:0]          rf_raddr2,
    output logic [3:0]          rf_waddr,
    output logic                rf_we,
    output logic                wb_sel,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         retired
`endif
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                illegal_q, illegal_d;

    logic [2:0]          dec_alu_ctrl;
    logic                dec_alu_l;
    iclass_t             dec_iclass;
    logic                dec_illegal;
    logic [ADDR_W-1:0]   target;

    ctrl_decode u_decode (
        .opcode   (ir_q[OPC_MSB:OPC_LSB]),
        .alu_ctrl (dec_alu_ctrl),
        .alu_l    (dec_alu_l),
        .iclass   (dec_iclass),
        .illegal  (dec_illegal)
    );

    assign target    = ir_q[ADDR_W-1:0];
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rf_raddr1 = ir_q[RS1_MSB:RS1_LSB];
    assign rf_raddr2 = ir_q[RS2_MSB:RS2_LSB];
    assign rf_waddr  = ir_q[RD_MSB:RD_LSB];
    assign illegal   = illegal_q;

    // State, pc, instruction and illegal-flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, register updates and Moore outputs from state and ir
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        alu_ctrl  = ALU_ADD;
        alu_l     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (dec_iclass == CLS_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_ctrl = dec_alu_ctrl;
                alu_l    = dec_alu_l;
                case (dec_iclass)
                    CLS_ALU: state_d = S_WB;
                    CLS_LD, CLS_ST: state_d = S_MEM;
                    CLS_JMP: begin
                        pc_d    = target;
                        state_d = S_FETCH;
                    end
                    CLS_BEQ: begin
                        if (alu_zero) pc_d = target;
                        state_d = S_FETCH;
                    end
                    CLS_BNE: begin
                        if (!alu_zero) pc_d = target;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_iclass == CLS_ST);
                if (dmem_valid) begin
                    state_d = (dec_iclass == CLS_LD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = (dec_iclass == CLS_LD);
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic retire_evt;

    // An instruction retires on WB exit, store completion or flow-change exit
    always_comb begin
        retire_evt = (state_q == S_WB)
                  || ((state_q == S_MEM) && (dec_iclass == CLS_ST) && dmem_valid)
                  || ((state_q == S_EXEC) && is_flow(dec_iclass));
    end

    // Saturating retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (retire_evt && (retired != '1)) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: a directed vector table followed by
// randomized instructions checked cycle by cycle against an
// instruction-level reference model of the control sequence.
module tb_ctrl_unit;

    localparam int unsigned AW = 8;

    localparam int K_ALU  = 0;
    localparam int K_JMP  = 1;
    localparam int K_BEQ  = 2;
    localparam int K_BNE  = 3;
    localparam int K_LD   = 4;
    localparam int K_ST   = 5;
    localparam int K_HALT = 6;
    localparam int K_ILL  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid = 1'b0;
    logic [18:0]   imem_data = '0;
    logic [2:0]    alu_ctrl;
    logic          alu_l;
    logic          alu_zero = 1'b0;
    logic [3:0]    rf_raddr1, rf_raddr2, rf_waddr;
    logic          rf_we, wb_sel, dmem_req, dmem_we;
    logic          dmem_valid = 1'b0;
    logic [AW-1:0] pc;
    logic          halted, illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]   retired;
`endif

    ctrl_unit #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_ctrl   (alu_ctrl),
        .alu_l      (alu_l),
        .alu_zero   (alu_zero),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_valid (dmem_valid),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] model_pc = 8'h00;

    typedef struct {
        logic [18:0] ins;
        int          fdly;
        int          mdly;
        logic        z;
        logic        chk_alu;
        logic [3:0]  alu;       // {alu_l, alu_ctrl} expected in EXEC
        logic [7:0]  pc_after;
    } vec_t;

    vec_t vt[17];

    function automatic int ref_kind(input logic [4:0] op);
        if (op <= 5'd6) return K_ALU;
        if (op >= 5'd8 && op <= 5'd10) return K_ALU;
        case (op)
            5'h0C:   return K_JMP;
            5'h0D:   return K_BEQ;
            5'h0E:   return K_BNE;
            5'h0F:   return K_LD;
            5'h10:   return K_ST;
            5'h1F:   return K_HALT;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [4:0] op);
        if (op <= 5'd6) return {1'b0, op[2:0]};
        if (op >= 5'd8 && op <= 5'd10) return {1'b1, 3'(op - 5'd8)};
        return 4'b0001;
    endfunction

    function automatic logic [7:0] ref_next_pc(input logic [7:0] cur, input logic [18:0] ins,
                                               input logic z);
        int k;
        k = ref_kind(ins[18:14]);
        if (k == K_JMP || (k == K_BEQ && z) || (k == K_BNE && !z)) return ins[7:0];
        return 8'((int'(cur) + 1) % 256);
    endfunction

    function automatic logic [18:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    function automatic logic [18:0] br(input logic [4:0] op, input logic [7:0] tgt);
        return {op, 6'b000000, tgt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {imem_req, halted, illegal, dmem_req, rf_we}, 32'b10000);
        chk("rst_pc", pc, 32'h00);
        rst      = 1'b0;
        model_pc = 8'h00;
    endtask

    // Drive one instruction through its full sequence, checking every cycle
    task automatic run_instr(input logic [18:0] ins, input int fdly, input int mdly,
                             input logic z, input logic chk_alu, input logic [3:0] exp_alu,
                             input logic [7:0] exp_pc);
        int k;
        k = ref_kind(ins[18:14]);
        for (int i = 0; i <= fdly; i++) begin
            @(negedge clk);
            chk("fetch_req", imem_req, 32'd1);
            chk("fetch_addr", imem_addr, model_pc);
            chk("fetch_idle", {rf_we, dmem_req, halted}, 32'd0);
            imem_valid = (i == fdly);
            imem_data  = (i == fdly) ? ins : 19'($urandom);
            dmem_valid = 1'b1;
        end
        model_pc = model_pc + 8'd1;
        @(negedge clk);
        chk("dec_pc", pc, model_pc);
        chk("dec_raddr", {rf_raddr1, rf_raddr2}, {ins[9:6], ins[5:2]});
        chk("dec_idle", {imem_req, rf_we, dmem_req, halted}, 32'd0);
        imem_valid = 1'b1;
        imem_data  = 19'($urandom);
        dmem_valid = 1'b0;
        if (k == K_HALT || k == K_ILL) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("halt_ctrl", {halted, illegal, imem_req, dmem_req, rf_we},
                    {27'd0, 1'b1, (k == K_ILL), 3'b000});
                chk("halt_pc", pc, model_pc);
                imem_valid = 1'b1;
            end
            imem_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (chk_alu) chk("exec_alu", {alu_l, alu_ctrl}, exp_alu);
        chk("exec_idle", {imem_req, rf_we, dmem_req}, 32'd0);
        imem_valid = 1'b0;
        alu_zero   = z;
        dmem_valid = 1'b1;
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= mdly; i++) begin
                @(negedge clk);
                chk("mem_ctrl", {dmem_req, dmem_we, rf_we, imem_req},
                    {28'd0, 1'b1, (k == K_ST), 2'b00});
                dmem_valid = (i == mdly);
                alu_zero   = ~z;
            end
        end
        if (k == K_ALU || k == K_LD) begin
            @(negedge clk);
            chk("wb_ctrl", {rf_we, wb_sel, rf_waddr, dmem_req, imem_req},
                {24'd0, 1'b1, (k == K_LD), ins[13:10], 2'b00});
            dmem_valid = 1'b0;
            imem_valid = 1'b1;
            imem_data  = 19'($urandom);
        end
        model_pc = exp_pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic [18:0] ins;
        logic        z;
        int          k;
        logic [4:0]  legal_ops[14] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                                      5'h08, 5'h09, 5'h0A, 5'h0C, 5'h0D, 5'h0E, 5'h0F};
        logic [4:0]  odd_ops[6]    = '{5'h07, 5'h0B, 5'h11, 5'h1B, 5'h1E, 5'h1F};

        vt[0]  = '{mk(5'h00, 4'd3, 4'd1, 4'd2),  0, 0, 1'b0, 1'b1, 4'b0000, 8'h01};
        vt[1]  = '{mk(5'h01, 4'd5, 4'd6, 4'd7),  0, 0, 1'b0, 1'b1, 4'b0001, 8'h02};
        vt[2]  = '{mk(5'h06, 4'd15, 4'd14, 4'd13), 0, 0, 1'b0, 1'b1, 4'b0110, 8'h03};
        vt[3]  = '{mk(5'h08, 4'd2, 4'd2, 4'd0),  2, 0, 1'b0, 1'b1, 4'b1000, 8'h04};
        vt[4]  = '{mk(5'h09, 4'd4, 4'd4, 4'd0),  0, 0, 1'b0, 1'b1, 4'b1001, 8'h05};
        vt[5]  = '{mk(5'h0A, 4'd6, 4'd7, 4'd0),  0, 0, 1'b0, 1'b1, 4'b1010, 8'h06};
        vt[6]  = '{br(5'h0D, 8'h20),             0, 0, 1'b1, 1'b1, 4'b0001, 8'h20};
        vt[7]  = '{br(5'h0D, 8'h40),             0, 0, 1'b0, 1'b1, 4'b0001, 8'h21};
        vt[8]  = '{br(5'h0E, 8'h40),             0, 0, 1'b0, 1'b1, 4'b0001, 8'h40};
        vt[9]  = '{br(5'h0E, 8'h10),             0, 0, 1'b1, 1'b1, 4'b0001, 8'h41};
        vt[10] = '{br(5'h0D, 8'h41),             1, 0, 1'b1, 1'b1, 4'b0001, 8'h41};
        vt[11] = '{mk(5'h0F, 4'd4, 4'd9, 4'd0),  0, 3, 1'b0, 1'b0, 4'b0000, 8'h42};
        vt[12] = '{mk(5'h10, 4'd0, 4'd2, 4'd3),  0, 0, 1'b0, 1'b0, 4'b0000, 8'h43};
        vt[13] = '{br(5'h0C, 8'hFF),             0, 0, 1'b0, 1'b0, 4'b0000, 8'hFF};
        vt[14] = '{mk(5'h00, 4'd1, 4'd1, 4'd1),  0, 0, 1'b0, 1'b1, 4'b0000, 8'h00};
        vt[15] = '{mk(5'h1B, 4'd0, 4'd0, 4'd0),  0, 0, 1'b0, 1'b0, 4'b0000, 8'h01};
        vt[16] = '{mk(5'h1F, 4'd0, 4'd0, 4'd0),  0, 0, 1'b0, 1'b0, 4'b0000, 8'h01};

        do_reset();

        for (int i = 0; i < 17; i++) begin
            run_instr(vt[i].ins, vt[i].fdly, vt[i].mdly, vt[i].z, vt[i].chk_alu,
                      vt[i].alu, vt[i].pc_after);
            k = ref_kind(vt[i].ins[18:14]);
            if (k == K_HALT || k == K_ILL) do_reset();
        end

        // Reset during a stalled data access abandons the request
        run_instr(br(5'h0C, 8'h30), 0, 0, 1'b0, 1'b0, 4'b0000, 8'h30);
        @(negedge clk);
        imem_valid = 1'b1;
        imem_data  = mk(5'h0F, 4'd1, 4'd2, 4'd0);
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        dmem_valid = 1'b0;
        @(negedge clk);
        chk("memwait_req", dmem_req, 32'd1);
        @(negedge clk);
        chk("memwait_req", dmem_req, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("memrst_ctrl", {dmem_req, imem_req, halted}, 32'b010);
        chk("memrst_pc", pc, 32'h00);
        rst      = 1'b0;
        model_pc = 8'h00;

        // Randomized instruction stream against the reference model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) op = odd_ops[$urandom_range(0, 5)];
            else if ($urandom_range(0, 9) == 0) op = 5'h10;
            else op = legal_ops[$urandom_range(0, 13)];
            ins = {op, 14'($urandom)};
            z   = 1'($urandom);
            k   = ref_kind(op);
            run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), z,
                      (k == K_ALU || k == K_BEQ || k == K_BNE), ref_alu(op),
                      ref_next_pc(model_pc, ins, z));
            if (k == K_HALT || k == K_ILL) do_reset();
        end

        @(negedge clk);
        chk("final_fetch", {imem_req, imem_addr}, {23'd0, 1'b1, model_pc});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
